// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use interlock, forward select,
// multi-cycle EX hold and branch flush for the MIPS pipe.
module pipe_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int MC_CYCLES  = 4,
  parameter int FW         = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic              ex_mem_bubble,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              mc_busy
);

  localparam int CW =
    (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  logic [STAGES:1]   v;
  logic [STAGES:1]   wr;
  logic [STAGES:1]   ld;
  logic [REG_AW-1:0] addr [1:STAGES];
  logic [CW-1:0]     cnt;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             use_src;
  logic [1:0]             hz;
  logic [1:0][FW-1:0]     code;
  logic                   stall;
  logic                   load_id;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};
  assign mc_busy = (cnt != '0);
  assign stall   = id_valid & (|hz);
  assign load_id = id_valid & ~flush & ~stall;

  // youngest in-flight producer picks the code or stalls
  always_comb begin
    hz   = '0;
    code = '0;
    for (int o = 0; o < 2; o++) begin
      for (int s = STAGES; s >= 1; s--) begin
        if (use_src[o] && (src[o] != '0) &&
            v[s] && wr[s] && (addr[s] == src[o])) begin
          if (s == STAGES) begin
            hz[o]   = 1'b0;
            code[o] = '0;
          end else if (s + 1 >=
                       (ld[s] ? LOAD_READY : ALU_READY)) begin
            hz[o]   = 1'b0;
            code[o] = FW'(s + 1);
          end else begin
            hz[o]   = 1'b1;
            code[o] = '0;
          end
        end
      end
    end
  end

  // pipe control: mc hold > flush > load-use > run
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    priority case (1'b1)
      mc_busy: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_hold       = 1'b1;
        ex_mem_bubble = 1'b1;
      end
      flush: begin
        id_ex_bubble = 1'b1;
      end
      stall: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // destination shadow, forward codes, mc counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      wr    <= '0;
      ld    <= '0;
      cnt   <= '0;
      fwd_a <= '0;
      fwd_b <= '0;
      for (int k = 1; k <= STAGES; k++)
        addr[k] <= '0;
    end else begin
      for (int k = 2; k <= STAGES; k++) begin
        v[k]    <= (mc_busy && k == 2) ? 1'b0 : v[k-1];
        wr[k]   <= wr[k-1];
        ld[k]   <= ld[k-1];
        addr[k] <= addr[k-1];
      end
      if (mc_busy) begin
        cnt <= cnt - CW'(1);
      end else begin
        v[1]    <= load_id;
        wr[1]   <= id_wr_en;
        ld[1]   <= id_is_load;
        addr[1] <= id_wr_addr;
        fwd_a   <= load_id ? code[0] : '0;
        fwd_b   <= load_id ? code[1] : '0;
        cnt     <= (load_id && id_is_mc) ?
                   CW'(MC_CYCLES - 1) : '0;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised interlock and forwarding controller for the pipelined MIPS core.
- Generalises the fixed 5-stage load-use detector and EX-stage forwarder to a configurable number of post-ID pipeline registers and a configurable load-data-ready stage.
- Adds two behaviours: a multi-cycle EX operation hold (mult/div), and a branch flush.
- Keeps its own registered shadow of every in-flight destination register, so the datapath does not have to export per-stage fields.

Parameters:
- REG_AW, 5: register address width.
- STAGES, 3: number of tracked pipeline registers after ID. Stage 1 = ID/EX, stage 2 = EX/MEM, ..., stage STAGES = MEM/WB.
- ALU_READY, 2: first stage whose register output holds an ALU result.
- LOAD_READY, 3: first stage whose register output holds load data. Must satisfy ALU_READY ≤ LOAD_READY ≤ STAGES.
- MC_CYCLES, 4: number of EX cycles a multi-cycle op occupies. Must be ≥ 1.
- FW, $clog2(STAGES+1): width of the forward-select code.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_use_rs, id_use_rt  in  1  ID instruction reads that operand
- id_wr_en  in  1  ID instruction writes a register
- id_wr_addr  in  REG_AW  its destination register
- id_is_load  in  1  ID instruction is a load
- id_is_mc  in  1  ID instruction is multi-cycle
- flush  in  1  taken branch resolved in EX; squash IF and ID
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- id_ex_bubble  out  1  load NOP control into ID/EX
- ex_hold  out  1  ID/EX and the EX unit hold their contents
- ex_mem_bubble  out  1  load NOP control into EX/MEM
- fwd_a, fwd_b  out  FW  operand source for the instruction now in EX. 0 = ID/EX register data; k = output of stage k.
- mc_busy  out  1  multi-cycle op occupying EX

Behaviour:
- Shadow state. Per stage k: v[k], wr[k], addr[k], ld[k], mc[k].
  - No stall and no hold: stage 1 ← ID fields, or a bubble if id_valid=0 or the hazard/flush rules below apply. Stage k ← stage k-1.
  - Hold: stage 1 keeps its contents, stage 2 ← bubble, stages ≥3 shift normally.
- Match. For each used ID operand r with r≠0, find the smallest s in 1..STAGES with v[s] & wr[s] & addr[s]==r. The youngest producer wins. No match means code 0.
- Ready test. The producer will sit at stage s+1 when the consumer reaches EX. Its need stage is LOAD_READY if ld[s], else ALU_READY.
  - s+1 ≥ need: next fwd code = s+1.
  - s = STAGES: code 0. The regfile is write-through.
  - s+1 < need: load-use hazard.
- Load-use hazard. Combinationally drive pc_write=0, if_id_write=0, id_ex_bubble=1. A bubble enters stage 1. The condition recomputes every cycle, so the stall lasts LOAD_READY-ALU_READY... until the producer is ready (defaults: exactly 1 cycle).
- Forward codes. fwd_a/fwd_b are registered, loaded together with stage 1. Bubbles load 0. The codes are held during ex_hold. They are meaningful only in an instruction's first EX cycle; the MC unit latches its operands then.
- Multi-cycle op.
  - When stage 1 loads an op with mc=1, an internal counter ← MC_CYCLES-1.
  - While the counter is nonzero: mc_busy=1, ex_hold=1, ex_mem_bubble=1, pc_write=0, if_id_write=0, id_ex_bubble=0. The counter decrements each cycle.
  - MC_CYCLES=1: no hold.
  - The op leaves EX on the cycle after the counter reaches 0.
- Flush.
  - Sets id_ex_bubble=1, pc_write=1, if_id_write=1, and stage 1 ← bubble.
  - Overrides a load-use stall in the same cycle.
  - Ignored while mc_busy=1; the branch cannot be in EX then.
- Priority: mc hold > flush > load-use stall > normal.
- Reset (async, rst_n=0):
  - All v=0, counter=0, fwd_a=fwd_b=0.
  - Outputs: pc_write=1, if_id_write=1, id_ex_bubble=0, ex_hold=0, ex_mem_bubble=0, mc_busy=0.
  - Reset mid-hold aborts the hold immediately.

Test Plan:
- add $3 then sub using $3 as rs: no stall. Next cycle fwd_a=2; the cycle after, a dependent or at distance 2 gets fwd_a=3.
- lw $4 then add using $4 as rt: one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. The add then enters EX with fwd_b=3.
- Writers of $5 at stages 1 and 2, consumer reads $5: fwd selects stage 1's producer (code 2). A writer of $0 never forwards and never stalls.
- mult, MC_CYCLES=4: mc_busy/ex_hold/ex_mem_bubble high for exactly 3 cycles, pc_write=0 for those 3 cycles, then normal flow.
- flush asserted together with a load-use hazard: pc_write=1, id_ex_bubble=1, no extra stall cycle.
- rst_n low in the 2nd hold cycle: all outputs reach reset values asynchronously. After release: no hold, fwd codes 0.
- Rerun all of the above with STAGES=4, LOAD_READY=4: a load-use stall lasts 2 cycles and then forwards code 4.
